fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/processor_help.sv | 27 ++
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/fetch.sv | 90 +++++++++
 tb/tb_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/processor_help.sv
`default_nettype none
// ============================================================================
// Module   : processor_help (package)
// Purpose  : Shared word, fetch-group types and helpers for the front end.
// Revision : 1.0 - initial release
// ============================================================================
package processor_help;

    typedef logic [31:0] Word;

    localparam int SUPER_SCALAR_WIDTH = 2;
    localparam int INSTRUCTION_BYTES  = 4;

    typedef struct packed {
        Word instruction;
        Word program_counter;
    } FetchResult;

    typedef FetchResult [SUPER_SCALAR_WIDTH-1:0] FetchGroup;

    // Byte address of a slot within a group starting at base.
    function automatic Word slot_address(input Word base, input int slot);
        return base + Word'(INSTRUCTION_BYTES * slot);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Two-entry FIFO of fetch groups with push/pop/flush, async reset.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import processor_help::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       i_push,
    input  FetchGroup  i_push_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output FetchGroup  o_head,
    output logic [1:0] o_count,
    output logic       o_empty
);

    localparam int c_DEPTH = 2;

    FetchGroup  r_mem [c_DEPTH];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic       w_full;
    logic       w_push;
    logic       w_pop;

    assign w_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_push  = i_push && (!w_full || i_pop);
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Purpose  : Superscalar instruction fetch: PC sequencing, 1-cycle imem, redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch
    import processor_help::*;
#(
    parameter Word RESET_VECTOR = 32'h0000_0000
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    output logic                                imem_request_valid_out,
    output Word                                 imem_address_out,
    input  Word        [SUPER_SCALAR_WIDTH-1:0] imem_data_in,
    input  logic                                decode_ready_in,
    output logic                                decode_valid_out,
    output FetchResult [SUPER_SCALAR_WIDTH-1:0] decode_payload_out,
    input  logic                                redirect_valid_in,
    input  Word                                 redirect_target_in
);

    localparam Word c_GROUP_BYTES = Word'(INSTRUCTION_BYTES * SUPER_SCALAR_WIDTH);
    localparam Word c_ALIGN_MASK  = ~Word'(INSTRUCTION_BYTES - 1);

    Word        r_pc;
    logic       r_inflight;
    Word        r_inflight_pc;

    FetchGroup  w_capture;
    FetchGroup  w_head;
    logic [1:0] w_count;
    logic       w_empty;
    logic       w_pop;
    logic       w_push;
    logic       w_issue;
    logic [2:0] w_occupancy;

    assign decode_valid_out   = !w_empty && !redirect_valid_in;
    assign decode_payload_out = w_head;
    assign w_pop              = decode_valid_out && decode_ready_in;
    assign w_push             = r_inflight && !redirect_valid_in;

    // Buffered plus in-flight groups, less the one leaving, must leave a free slot.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_issue     = !rst_in && !redirect_valid_in
                         && (w_occupancy < (3'd2 + {2'b00, w_pop}));

    assign imem_request_valid_out = w_issue;
    assign imem_address_out       = r_pc;

    always_comb begin
        w_capture = '0;
        for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
            w_capture[i].instruction     = imem_data_in[i];
            w_capture[i].program_counter = slot_address(r_inflight_pc, i);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pc          <= RESET_VECTOR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_valid_in) begin
                r_pc <= redirect_target_in & c_ALIGN_MASK;
            end else if (w_issue) begin
                r_pc          <= r_pc + c_GROUP_BYTES;
                r_inflight_pc <= r_pc;
            end
        end
    end

    fetch_buffer u_buffer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_push      (w_push),
        .i_push_data (w_capture),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid_in),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch
// Purpose  : Directed self-checking bench for fetch (width 2) incl. wrap instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch;
    import processor_help::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b1;
    logic redirect = 1'b0;
    Word  target = '0;

    logic                                req_valid;
    Word                                 req_addr;
    Word        [SUPER_SCALAR_WIDTH-1:0] imem_data = '0;
    logic                                dec_valid;
    FetchResult [SUPER_SCALAR_WIDTH-1:0] dec_payload;

    logic                                wrap_req;
    Word                                 wrap_addr;
    Word        [SUPER_SCALAR_WIDTH-1:0] tie_data = '0;
    logic                                wrap_valid;
    FetchResult [SUPER_SCALAR_WIDTH-1:0] wrap_payload;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch u_dut (
        .clk_in                 (clk),
        .rst_in                 (rst),
        .imem_request_valid_out (req_valid),
        .imem_address_out       (req_addr),
        .imem_data_in           (imem_data),
        .decode_ready_in        (ready),
        .decode_valid_out       (dec_valid),
        .decode_payload_out     (dec_payload),
        .redirect_valid_in      (redirect),
        .redirect_target_in     (target)
    );

    fetch #(.RESET_VECTOR(32'hFFFF_FFF8)) u_wrap (
        .clk_in                 (clk),
        .rst_in                 (rst),
        .imem_request_valid_out (wrap_req),
        .imem_address_out       (wrap_addr),
        .imem_data_in           (tie_data),
        .decode_ready_in        (ready),
        .decode_valid_out       (wrap_valid),
        .decode_payload_out     (wrap_payload),
        .redirect_valid_in      (redirect),
        .redirect_target_in     (target)
    );

    function automatic Word instr_of(input Word a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Instruction memory: one-cycle read latency, contents derived from address.
    always @(posedge clk) begin
        if (req_valid) begin
            imem_data[0] <= instr_of(req_addr);
            imem_data[1] <= instr_of(req_addr + 32'd4);
        end
    end

    task automatic chk(input string tag, input Word obs, input Word exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_grp(input string tag, input Word pc);
        chk({tag, ".valid"}, Word'(dec_valid), 32'd1);
        chk({tag, ".pc0"},   dec_payload[0].program_counter, pc);
        chk({tag, ".pc1"},   dec_payload[1].program_counter, pc + 32'd4);
        chk({tag, ".ins0"},  dec_payload[0].instruction, instr_of(pc));
        chk({tag, ".ins1"},  dec_payload[1].instruction, instr_of(pc + 32'd4));
    endtask

    task automatic chk_req(input string tag, input logic v, input Word a);
        chk({tag, ".req"}, Word'(req_valid), Word'(v));
        if (v) chk({tag, ".addr"}, req_addr, a);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, Word'(dec_valid), 32'd0);
        chk({tag, ".req"},   Word'(req_valid), 32'd0);
        chk({tag, ".pl0"},   dec_payload[0].program_counter, 32'd0);
        chk({tag, ".pl1"},   dec_payload[1].instruction, 32'd0);
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench at the sample point of cycle 1 after release.
    task automatic do_reset(input logic check_now, input logic rdy);
        rst = 1'b1;
        #1;
        if (check_now) chk_idle("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_idle("rst_hold");
        #1;
        rst      = 1'b0;
        ready    = rdy;
        redirect = 1'b0;
        #1;
    endtask

    initial begin
        // Power-on reset, streaming with ready held high, wrap instance alongside
        do_reset(1'b0, 1'b1);
        chk_req("s1c1", 1'b1, 32'h0);
        chk("s1c1.dv", Word'(dec_valid), 32'd0);
        chk("wrap.c1.addr", wrap_addr, 32'hFFFF_FFF8);
        chk("wrap.c1.dv", Word'(wrap_valid), 32'd0);
        cyc(); #1;
        chk_req("s1c2", 1'b1, 32'h8);
        chk("s1c2.dv", Word'(dec_valid), 32'd0);
        chk("wrap.c2.req", Word'(wrap_req), 32'd1);
        chk("wrap.c2.addr", wrap_addr, 32'h0000_0000);
        cyc(); #1;
        chk_req("s1c3", 1'b1, 32'h10);
        chk_grp("s1c3", 32'h0);
        chk("wrap.c3.pc0", wrap_payload[0].program_counter, 32'hFFFF_FFF8);
        chk("wrap.c3.pc1", wrap_payload[1].program_counter, 32'hFFFF_FFFC);
        cyc(); #1;
        chk_grp("s1c4", 32'h8);
        cyc(); #1;
        chk_grp("s1c5", 32'h10);

        // Mid-stream async reset, then back-pressure fills the buffer
        do_reset(1'b1, 1'b1);
        chk_req("s2c1", 1'b1, 32'h0);
        cyc(); #1;
        chk_req("s2c2", 1'b1, 32'h8);
        cyc(); ready = 1'b0; #1;
        chk_grp("s2c3", 32'h0);
        chk_req("s2c3", 1'b0, 32'h0);
        cyc(); #1;
        chk_grp("s2c4", 32'h0);
        chk_req("s2c4", 1'b0, 32'h0);
        chk("s2c4.pc_hold", req_addr, 32'h10);
        cyc(); #1;
        chk_grp("s2c5", 32'h0);
        chk_req("s2c5", 1'b0, 32'h0);
        cyc(); ready = 1'b1; #1;
        chk_grp("s2c6", 32'h0);
        chk_req("s2c6", 1'b1, 32'h10);
        cyc(); #1;
        chk_grp("s2c7", 32'h8);
        chk_req("s2c7", 1'b1, 32'h18);
        cyc(); #1;
        chk_grp("s2c8", 32'h10);
        cyc(); #1;
        chk_grp("s2c9", 32'h18);

        // Redirect to a misaligned target in cycle 6
        do_reset(1'b1, 1'b1);
        repeat (4) cyc();
        #1;
        chk_grp("s3c5", 32'h10);
        cyc(); redirect = 1'b1; target = 32'h0000_0103; #1;
        chk("s3c6.dv", Word'(dec_valid), 32'd0);
        chk("s3c6.req", Word'(req_valid), 32'd0);
        cyc(); redirect = 1'b0; #1;
        chk_req("s3c7", 1'b1, 32'h100);
        chk("s3c7.dv", Word'(dec_valid), 32'd0);
        cyc(); #1;
        chk_req("s3c8", 1'b1, 32'h108);
        chk("s3c8.dv", Word'(dec_valid), 32'd0);
        cyc(); #1;
        chk_grp("s3c9", 32'h100);
        cyc(); #1;
        chk_grp("s3c10", 32'h108);

        // Redirect while the buffer is full and decode becomes ready
        do_reset(1'b1, 1'b0);
        chk_req("s4c1", 1'b1, 32'h0);
        cyc(); #1;
        chk_req("s4c2", 1'b1, 32'h8);
        cyc(); #1;
        chk_req("s4c3", 1'b0, 32'h0);
        cyc(); #1;
        chk_grp("s4c4", 32'h0);
        chk_req("s4c4", 1'b0, 32'h0);
        cyc(); ready = 1'b1; redirect = 1'b1; target = 32'h0000_0200; #1;
        chk("s4c5.dv", Word'(dec_valid), 32'd0);
        chk("s4c5.req", Word'(req_valid), 32'd0);
        cyc(); redirect = 1'b0; #1;
        chk("s4c6.dv", Word'(dec_valid), 32'd0);
        chk_req("s4c6", 1'b1, 32'h200);
        cyc(); #1;
        chk("s4c7.dv", Word'(dec_valid), 32'd0);
        chk_req("s4c7", 1'b1, 32'h208);
        cyc(); #1;
        chk_grp("s4c8", 32'h200);
        cyc(); #1;
        chk_grp("s4c9", 32'h208);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
